// File: rtl/loop_drv_deadtime_ctrl.sv
// Break-before-make sequencer for the LOOP driver half-bridge.
// Converts PWM demand into top/bottom gate enables. A gate is enabled only
// after the dead time has elapsed and the opposite gate-sense reads low.
// Shoot-through and turn-off timeout latch a sticky fault.
module loop_drv_deadtime_ctrl #(
  parameter int DT_W       = 6,
  parameter int FB_TIMEOUT = 32,
  parameter int TMO_W      = 6
) (
  input  logic            CELCLK,
  input  logic            CELRSTN,
  input  logic            CELV,
  input  logic            CELG,
  input  logic            SUB,
  input  logic            en,
  input  logic            pwm_in,
  input  logic [DT_W-1:0] dt_top,
  input  logic [DT_W-1:0] dt_bot,
  input  logic            fb_top,
  input  logic            fb_bot,
  input  logic            fault_clr,
  output logic            top_on,
  output logic            bot_on,
  output logic            fault,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DT_TOP = 3'd1,
    S_TOP_ON = 3'd2,
    S_DT_BOT = 3'd3,
    S_BOT_ON = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  // Last timeout count value before the fault fires.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FB_TIMEOUT - 1);

  state_t            r_state;
  logic              r_top_on;
  logic              r_bot_on;
  logic              r_fault;
  logic [DT_W-1:0]   r_dt_cnt;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic              r_fb_top_s1;
  logic              r_fb_top_s2;
  logic              r_fb_bot_s1;
  logic              r_fb_bot_s2;

  state_t            w_state_nxt;
  logic [DT_W-1:0]   w_dt_cnt_nxt;
  logic [TMO_W-1:0]  w_tmo_cnt_nxt;
  logic              w_top_side;
  logic              w_fbs_opp;
  logic [DT_W-1:0]   w_dt_sel;
  logic [DT_W-1:0]   w_dt_lim;
  logic [DT_W-1:0]   w_dt_cnt_inc;
  logic              w_unused_pins;

  // Power and substrate pins carry no logic function.
  assign w_unused_pins = CELV ^ CELG ^ SUB;

  // Two-flop synchronisers for the asynchronous gate-sense inputs.
  // Reset value 1 treats both gates as "on" until they are sensed low.
  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      r_fb_top_s1 <= 1'b1;
      r_fb_top_s2 <= 1'b1;
      r_fb_bot_s1 <= 1'b1;
      r_fb_bot_s2 <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let s2 take the old s1, forming a true two-stage chain.
      r_fb_top_s1 <= fb_top;
      r_fb_top_s2 <= r_fb_top_s1;
      r_fb_bot_s1 <= fb_bot;
      r_fb_bot_s2 <= r_fb_bot_s1;
    end
  end

  // Side selection shared by the dead-time and on states of each half.
  assign w_top_side   = (r_state == S_DT_TOP) || (r_state == S_TOP_ON);
  assign w_fbs_opp    = w_top_side ? r_fb_bot_s2 : r_fb_top_s2;
  assign w_dt_sel     = (r_state == S_DT_TOP) ? dt_top : dt_bot;
  // A programmed dead time of 0 behaves as 1, so the limit is max(dt,1)-1.
  assign w_dt_lim     = (w_dt_sel == '0) ? '0 : (w_dt_sel - DT_W'(1));
  // Dead-time counter saturates at all-ones rather than wrapping.
  assign w_dt_cnt_inc = (&r_dt_cnt) ? r_dt_cnt : (r_dt_cnt + DT_W'(1));

  // Next-state and counter logic; counters run only while holding a dead-time state.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    w_state_nxt   = r_state;
    w_dt_cnt_nxt  = '0;
    w_tmo_cnt_nxt = '0;
    unique case (r_state)
      S_IDLE: begin
        if (en) w_state_nxt = pwm_in ? S_DT_TOP : S_DT_BOT;
      end
      S_DT_TOP, S_DT_BOT: begin
        if (!en) begin
          w_state_nxt = S_IDLE;
        end else if (w_fbs_opp && (r_tmo_cnt >= TMO_LAST)) begin
          w_state_nxt = S_FAULT;
        end else if (pwm_in != (r_state == S_DT_TOP)) begin
          w_state_nxt = pwm_in ? S_DT_TOP : S_DT_BOT;
        end else if (!w_fbs_opp && (r_dt_cnt >= w_dt_lim)) begin
          w_state_nxt = (r_state == S_DT_TOP) ? S_TOP_ON : S_BOT_ON;
        end else begin
          w_dt_cnt_nxt  = w_dt_cnt_inc;
          w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(w_fbs_opp);
        end
      end
      S_TOP_ON, S_BOT_ON: begin
        if (!en) begin
          w_state_nxt = S_IDLE;
        end else if (w_fbs_opp) begin
          w_state_nxt = S_FAULT;
        end else if (pwm_in != (r_state == S_TOP_ON)) begin
          w_state_nxt = pwm_in ? S_DT_TOP : S_DT_BOT;
        end
      end
      S_FAULT: begin
        if (fault_clr && !en) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counters and registered output decode of the next state.
  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      r_state   <= S_IDLE;
      r_dt_cnt  <= '0;
      r_tmo_cnt <= '0;
      r_top_on  <= 1'b0;
      r_bot_on  <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_dt_cnt  <= w_dt_cnt_nxt;
      r_tmo_cnt <= w_tmo_cnt_nxt;
      r_top_on  <= (w_state_nxt == S_TOP_ON);
      r_bot_on  <= (w_state_nxt == S_BOT_ON);
      r_fault   <= (w_state_nxt == S_FAULT);
    end
  end

  assign top_on = r_top_on;
  assign bot_on = r_bot_on;
  assign fault  = r_fault;
  assign state  = r_state;

endmodule

// File: tb/tb_loop_drv_deadtime_ctrl.sv
// Directed bench for loop_drv_deadtime_ctrl. Observed vector is
// {state[2:0], top_on, bot_on, fault}, sampled 2 time units after each rising edge.
module tb_loop_drv_deadtime_ctrl;

  localparam logic [5:0] O_IDLE   = {3'd0, 3'b000};
  localparam logic [5:0] O_DT_TOP = {3'd1, 3'b000};
  localparam logic [5:0] O_TOP    = {3'd2, 3'b100};
  localparam logic [5:0] O_DT_BOT = {3'd3, 3'b000};
  localparam logic [5:0] O_BOT    = {3'd4, 3'b010};
  localparam logic [5:0] O_FAULT  = {3'd5, 3'b001};

  logic       CELCLK = 1'b0;
  logic       CELRSTN = 1'b0;
  logic       en = 1'b0;
  logic       pwm_in = 1'b0;
  logic [5:0] dt_top = 6'd4;
  logic [5:0] dt_bot = 6'd6;
  logic       fb_top = 1'b1;
  logic       fb_bot = 1'b0;
  logic       fault_clr = 1'b0;
  logic       top_on;
  logic       bot_on;
  logic       fault;
  logic [2:0] state;
  logic [5:0] obs;

  int n_cmp  = 0;
  int n_fail = 0;

  loop_drv_deadtime_ctrl #(.DT_W(6), .FB_TIMEOUT(32), .TMO_W(6)) dut (
    .CELCLK    (CELCLK),
    .CELRSTN   (CELRSTN),
    .CELV      (1'b1),
    .CELG      (1'b0),
    .SUB       (1'b0),
    .en        (en),
    .pwm_in    (pwm_in),
    .dt_top    (dt_top),
    .dt_bot    (dt_bot),
    .fb_top    (fb_top),
    .fb_bot    (fb_bot),
    .fault_clr (fault_clr),
    .top_on    (top_on),
    .bot_on    (bot_on),
    .fault     (fault),
    .state     (state)
  );

  assign obs = {state, top_on, bot_on, fault};

  always #5 CELCLK = ~CELCLK;

  // Advance n rising edges and settle past the edge.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge CELCLK);
    #2;
  endtask

  task automatic test_reset();
    tick(2);
    n_cmp++;
    if (obs !== O_IDLE) begin
      $display("FAIL reset_state obs=%b exp=%b", obs, O_IDLE);
      n_fail++;
    end
    en = 1'b1; pwm_in = 1'b1; dt_top = 6'd4; fb_bot = 1'b0; fb_top = 1'b1;
    CELRSTN = 1'b1;
  endtask

  // dt_top=4: top_on rises 4 edges after DT_TOP is entered.
  task automatic test_top_start();
    tick();
    n_cmp++;
    if (obs !== O_DT_TOP) begin
      $display("FAIL start_enter_dt_top obs=%b exp=%b", obs, O_DT_TOP); n_fail++;
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_cmp++;
      if (obs !== O_DT_TOP) begin
        $display("FAIL start_dt_wait%0d obs=%b exp=%b", i, obs, O_DT_TOP); n_fail++;
      end
    end
    tick();
    n_cmp++;
    if (obs !== O_TOP) begin
      $display("FAIL start_top_on obs=%b exp=%b", obs, O_TOP); n_fail++;
    end
  endtask

  // pwm 1->0: top drops same edge; fb_top low 2 edges later; bot rises 6 edges later.
  task automatic test_top_to_bot();
    pwm_in = 1'b0; dt_bot = 6'd6;
    tick();
    n_cmp++;
    if (obs !== O_DT_BOT) begin
      $display("FAIL t2b_top_drop obs=%b exp=%b", obs, O_DT_BOT); n_fail++;
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_cmp++;
      if (obs !== O_DT_BOT) begin
        $display("FAIL t2b_dt_wait%0d obs=%b exp=%b", i, obs, O_DT_BOT); n_fail++;
      end
      if (i == 2) fb_top = 1'b0;
    end
    tick();
    n_cmp++;
    if (obs !== O_BOT) begin
      $display("FAIL t2b_bot_on obs=%b exp=%b", obs, O_BOT); n_fail++;
    end
  endtask

  // fb_top stuck high in DT_BOT: fault after 32 edges; clear only with en=0.
  task automatic test_timeout();
    en = 1'b0;
    tick();
    n_cmp++;
    if (obs !== O_IDLE) begin
      $display("FAIL tmo_en_low_idle obs=%b exp=%b", obs, O_IDLE); n_fail++;
    end
    fb_top = 1'b1;
    tick(3);
    en = 1'b1; pwm_in = 1'b0;
    tick();
    n_cmp++;
    if (obs !== O_DT_BOT) begin
      $display("FAIL tmo_enter_dt_bot obs=%b exp=%b", obs, O_DT_BOT); n_fail++;
    end
    for (int i = 1; i <= 31; i++) begin
      tick();
      n_cmp++;
      if (obs !== O_DT_BOT) begin
        $display("FAIL tmo_wait%0d obs=%b exp=%b", i, obs, O_DT_BOT); n_fail++;
      end
    end
    tick();
    n_cmp++;
    if (obs !== O_FAULT) begin
      $display("FAIL tmo_fault obs=%b exp=%b", obs, O_FAULT); n_fail++;
    end
    fault_clr = 1'b1;
    tick();
    n_cmp++;
    if (obs !== O_FAULT) begin
      $display("FAIL tmo_clr_with_en obs=%b exp=%b", obs, O_FAULT); n_fail++;
    end
    en = 1'b0;
    tick();
    n_cmp++;
    if (obs !== O_IDLE) begin
      $display("FAIL tmo_clr_to_idle obs=%b exp=%b", obs, O_IDLE); n_fail++;
    end
    fault_clr = 1'b0;
  endtask

  // fb_bot pulse in TOP_ON: fault 2 edges after the pulse is first sampled.
  task automatic test_shoot_through();
    fb_top = 1'b0; fb_bot = 1'b0;
    tick(3);
    dt_top = 6'd4; pwm_in = 1'b1; en = 1'b1;
    tick();
    n_cmp++;
    if (obs !== O_DT_TOP) begin
      $display("FAIL st_enter_dt_top obs=%b exp=%b", obs, O_DT_TOP); n_fail++;
    end
    tick(4);
    n_cmp++;
    if (obs !== O_TOP) begin
      $display("FAIL st_top_on obs=%b exp=%b", obs, O_TOP); n_fail++;
    end
    fb_bot = 1'b1;
    for (int i = 0; i <= 1; i++) begin
      tick();
      n_cmp++;
      if (obs !== O_TOP) begin
        $display("FAIL st_sync_delay%0d obs=%b exp=%b", i, obs, O_TOP); n_fail++;
      end
    end
    tick();
    n_cmp++;
    if (obs !== O_FAULT) begin
      $display("FAIL st_fault obs=%b exp=%b", obs, O_FAULT); n_fail++;
    end
    fb_bot = 1'b0;
    tick(2);
    n_cmp++;
    if (obs !== O_FAULT) begin
      $display("FAIL st_fault_sticky obs=%b exp=%b", obs, O_FAULT); n_fail++;
    end
    en = 1'b0; fault_clr = 1'b1;
    tick();
    n_cmp++;
    if (obs !== O_IDLE) begin
      $display("FAIL st_clr_to_idle obs=%b exp=%b", obs, O_IDLE); n_fail++;
    end
    fault_clr = 1'b0;
  endtask

  // pwm 1->0->1 inside DT_BOT (dt_bot=10): bottom never on, top back after dt_top.
  task automatic test_pwm_glitch();
    tick(3);
    en = 1'b1; pwm_in = 1'b1; dt_top = 6'd4;
    tick(5);
    n_cmp++;
    if (obs !== O_TOP) begin
      $display("FAIL gl_top_on obs=%b exp=%b", obs, O_TOP); n_fail++;
    end
    dt_bot = 6'd10; pwm_in = 1'b0;
    for (int i = 0; i <= 2; i++) begin
      tick();
      n_cmp++;
      if (obs !== O_DT_BOT) begin
        $display("FAIL gl_dt_bot%0d obs=%b exp=%b", i, obs, O_DT_BOT); n_fail++;
      end
    end
    pwm_in = 1'b1;
    for (int i = 0; i <= 3; i++) begin
      tick();
      n_cmp++;
      if (obs !== O_DT_TOP) begin
        $display("FAIL gl_dt_top%0d obs=%b exp=%b", i, obs, O_DT_TOP); n_fail++;
      end
    end
    for (int i = 0; i <= 4; i++) begin
      tick();
      n_cmp++;
      if (obs !== O_TOP) begin
        $display("FAIL gl_top_hold%0d obs=%b exp=%b", i, obs, O_TOP); n_fail++;
      end
    end
  endtask

  // Shrinking dt_bot mid dead-time takes effect against the running count.
  task automatic test_dt_change();
    dt_bot = 6'd20; pwm_in = 1'b0;
    tick();
    tick(3);
    n_cmp++;
    if (obs !== O_DT_BOT) begin
      $display("FAIL dtc_still_dt obs=%b exp=%b", obs, O_DT_BOT); n_fail++;
    end
    dt_bot = 6'd2;
    tick();
    n_cmp++;
    if (obs !== O_BOT) begin
      $display("FAIL dtc_bot_on obs=%b exp=%b", obs, O_BOT); n_fail++;
    end
  endtask

  // dt_top=0 acts as 1; async reset in TOP_ON drops the enable with no clock edge.
  task automatic test_dt_zero_async_reset();
    dt_top = 6'd0; pwm_in = 1'b1;
    tick();
    n_cmp++;
    if (obs !== O_DT_TOP) begin
      $display("FAIL dz_dt_top obs=%b exp=%b", obs, O_DT_TOP); n_fail++;
    end
    tick();
    n_cmp++;
    if (obs !== O_TOP) begin
      $display("FAIL dz_top_on obs=%b exp=%b", obs, O_TOP); n_fail++;
    end
    #1 CELRSTN = 1'b0;
    #1;
    n_cmp++;
    if (obs !== O_IDLE) begin
      $display("FAIL ar_async_drop obs=%b exp=%b", obs, O_IDLE); n_fail++;
    end
    tick();
    n_cmp++;
    if (obs !== O_IDLE) begin
      $display("FAIL ar_held_in_reset obs=%b exp=%b", obs, O_IDLE); n_fail++;
    end
    en = 1'b0;
    CELRSTN = 1'b1;
  endtask

  initial begin
    test_reset();
    test_top_start();
    test_top_to_bot();
    test_timeout();
    test_shoot_through();
    test_pwm_glitch();
    test_dt_change();
    test_dt_zero_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Time bound so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog time limit reached compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
